seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle 32-bit signed integer divider: the inverse of the multi-cycle multiplier.
//  Sits beside the single-cycle ALU ops (add/sub/and/or/shift).
//  Quotient and remainder come from 32 iterations of a restoring shift-subtract step.
//  Start/ready handshake so the pipeline stalls while a divide runs.
// PARAMETERS
//  WIDTH   32  operand/result width; only 32 is verified
//  CNT_W   6   iteration counter width; must hold WIDTH+1
// PORTS
//  clock           in   1      single clock, rising edge
//  reset           in   1      asynchronous, active-high; clears all state immediately
//  ctrl_DIV        in   1      start pulse; operands sampled on the same edge
//  data_operandA   in   WIDTH  dividend, two's complement
//  data_operandB   in   WIDTH  divisor, two's complement
//  data_result     out  WIDTH  quotient, truncated toward zero
//  data_remainder  out  WIDTH  remainder; sign follows the dividend
//  data_exception  out  1      divide-by-zero or overflow; valid while data_resultRDY=1
//  data_resultRDY  out  1      one-cycle pulse when the result is valid
//  busy            out  1      high from start edge through the ready cycle
// BEHAVIOUR
//  Reset: state=IDLE; data_result, data_remainder, data_exception, data_resultRDY, busy,
//   counter and working registers = 0.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  Start: ctrl_DIV=1 at edge E0 in any state (IDLE, BUSY or DONE):
//   - latch |A| and |B| (magnitude as WIDTH-bit unsigned, so |0x80000000| = 0x80000000)
//   - latch the sign of A and the sign of A^B
//   - clear the partial remainder; counter=0; state=BUSY; busy=1
//   - a start while BUSY aborts the running divide with no RDY pulse for it
//  BUSY, edges E1..E32:
//   - shift {rem,quo} left by 1; trial = rem - |B| (WIDTH+1 bits)
//   - trial >= 0: rem=trial, quo[0]=1; otherwise quo[0]=0
//   - counter increments each edge; at counter==WIDTH-1 go to DONE
//  DONE, edge E33:
//   - data_result = quotient, negated if sign(A^B)
//   - data_remainder = remainder, negated if sign(A)
//   - data_resultRDY=1 for exactly this one cycle; state=IDLE at E34
//   - fixed latency: RDY is high in the cycle after E33, i.e. 33 edges after the start edge
//  Exceptions, flagged at the same E33 and with the same latency:
//   - B==0: data_exception=1, data_result=0, data_remainder=A
//   - A==0x80000000 and B==0xFFFFFFFF: data_exception=1, data_result=0x80000000, data_remainder=0
//   - otherwise data_exception=0
//  Outputs: data_result, data_remainder and data_exception hold their last values until the
//   next DONE or reset; they are not cleared on a new start.
//  busy=1 from E0 through the RDY cycle, then 0.
//  Simultaneous ctrl_DIV and RDY: the new start wins; RDY for the old op still pulses that cycle.
//  Reset asserted mid-operation: all state returns to reset values asynchronously; no RDY pulse.
//  Operand changes after E0 have no effect.
// STRUCTURE
//  Shared include (div_defs.vh): state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2; WIDTH; INT_MIN.
//  Sub-module div_step: combinational single restoring step.
//   - inputs {rem, quo, divisor}; outputs {rem', quo'}
//   - instantiated once and reused every cycle
//  Top level: FSM, counter, operand magnitude/sign logic, output sign fix-up.
// TESTING
//  1. 100 / 7 -> result 14, remainder 2, exception 0; RDY exactly 33 edges after start, one cycle.
//  2. -100 / 7 -> result -14 (0xFFFFFFF2), remainder -2; 100 / -7 -> -14, remainder 2.
//  3. 5 / 0 -> exception 1, result 0, remainder 5; same 33-edge latency.
//  4. 0x80000000 / -1 -> exception 1, result 0x80000000;
//     0x80000000 / 2 -> 0xC0000000, exception 0.
//  5. Start 100/7, restart at E10 with 9/3 -> single RDY 33 edges after E10, result 3, remainder 0.
//  6. Reset at E15 mid-divide -> all outputs 0 immediately, busy 0, no RDY;
//     a following 7/7 gives result 1.
//  Plus 1000 random operand pairs vs a behavioural reference ($signed / and %).

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential signed divider: default widths,
// FSM state encodings and the most negative operand value.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring shift-subtract step on unsigned magnitudes.
// The top level instantiates this once and feeds it back every cycle.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The partial remainder stays below the divisor (at most 2^(WIDTH-1)),
    // so its top bit is always clear and the shift never loses information.
    // With a zero divisor every trial succeeds and the remainder collects
    // the dividend bits one by one, which also never overflows.
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;

    assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, divisor};

    // Keep the subtraction only when it did not go negative.
    always_comb begin
        rem_next = rem_shift;
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: 32 restoring steps on operand magnitudes,
// then a sign fix-up and exception override, reported with a RDY pulse.
//
// Handshake: ctrl_DIV is a single-cycle start; the operands are captured on
// the same rising edge. A start is accepted in any state and discards any
// divide in flight. busy rises on the start edge and stays high through the
// cycle in which data_resultRDY pulses; data_resultRDY is high for exactly
// one cycle, 33 edges after the start edge, and the result outputs are valid
// from then until the next completed divide or reset.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic             a_neg;
    logic             q_neg;
    logic             b_zero;
    logic             ovf;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] res_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             exc_fix;

    assign fsm_state = state;

    // Magnitudes as unsigned WIDTH-bit values; |MIN_VAL| wraps to MIN_VAL,
    // which is exactly the right unsigned magnitude.
    always_comb begin
        a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign fix-up of the finished magnitudes, overridden by the two exceptions.
    always_comb begin
        res_fix = q_neg ? -quo_q : quo_q;
        rem_fix = a_neg ? -rem_q : rem_q;
        exc_fix = 1'b0;
        if (b_zero) begin
            // Remainder magnitude equals |A| here, so rem_fix is A itself.
            res_fix = '0;
            exc_fix = 1'b1;
        end else if (ovf) begin
            res_fix = MIN_VAL;
            rem_fix = '0;
            exc_fix = 1'b1;
        end
    end

    // FSM, iteration counter, working registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            div_q          <= '0;
            a_neg          <= 1'b0;
            q_neg          <= 1'b0;
            b_zero         <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_DIV) begin
            // A new start always wins, even over a divide in flight.
            state          <= ST_BUSY;
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= a_mag;
            div_q          <= b_mag;
            a_neg          <= data_operandA[WIDTH-1];
            q_neg          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            b_zero         <= (data_operandB == '0);
            ovf            <= (data_operandA == MIN_VAL) && (data_operandB == ALL_ONES);
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
        end else begin
            case (state)
                ST_BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE edge publishes the result; the next one retires.
                    if (!data_resultRDY) begin
                        data_result    <= res_fix;
                        data_remainder <= rem_fix;
                        data_exception <= exc_fix;
                        data_resultRDY <= 1'b1;
                    end else begin
                        data_resultRDY <= 1'b0;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, restart / reset /
// back-to-back corner sequences, and random operands against an
// arithmetic reference model.
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_r_q[$];
    logic        exp_e_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[13];

    seq_divider dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy),
        .fsm_state      (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain signed division with the two exception cases.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic e);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (sb == 0) begin
            q = 32'd0; r = a; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e = 1'b1;
        end else begin
            q = sa / sb; r = sa % sb; e = 1'b0;
        end
    endtask

    // driver: assert start now, operands captured at the next rising edge
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Count edges after the start edge until RDY is seen; -1 on timeout.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] q, input logic [31:0] r, input logic e);
        int lat;
        @(negedge clock);
        drive_start(a, b);
        check({name, ".busy_start"}, 32'(busy), 32'd1);
        wait_rdy(lat);
        check({name, ".latency"}, 32'(lat), 32'd33);
        check({name, ".result"}, data_result, q);
        check({name, ".remainder"}, data_remainder, r);
        check({name, ".exception"}, 32'(data_exception), 32'(e));
        check({name, ".busy_rdy"}, 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        check({name, ".rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
        check({name, ".busy_after"}, 32'(busy), 32'd0);
        check({name, ".result_hold"}, data_result, q);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;

        vecs[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1]  = '{-32'd100, 32'd7, 32'hFFFF_FFF2, -32'd2, 1'b0};
        vecs[2]  = '{32'd100, -32'd7, 32'hFFFF_FFF2, 32'd2, 1'b0};
        vecs[3]  = '{32'd5, 32'd0, 32'd0, 32'd5, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0};
        vecs[6]  = '{-32'd7, -32'd2, 32'd3, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[8]  = '{32'd7, 32'h8000_0000, 32'd0, 32'd7, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0};
        vecs[10] = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1};
        vecs[11] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[12] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 1'b0};

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.result", data_result, 32'd0);
        check("reset.remainder", data_remainder, 32'd0);
        check("reset.exception", 32'(data_exception), 32'd0);
        check("reset.rdy", 32'(data_resultRDY), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 13; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e);
        end

        // restart at E10 aborts 100/7; only 9/3 reports
        @(negedge clock);
        drive_start(32'd100, 32'd7);
        pulses = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        drive_start(32'd9, 32'd3);
        wait_rdy(lat);
        check("restart.no_early_rdy", 32'(pulses), 32'd0);
        check("restart.latency", 32'(lat), 32'd33);
        check("restart.result", data_result, 32'd3);
        check("restart.remainder", data_remainder, 32'd0);
        @(posedge clock);
        #1;
        check("restart.rdy_one_cycle", 32'(data_resultRDY), 32'd0);

        // start coinciding with RDY: old pulse stands, new op runs
        @(negedge clock);
        drive_start(32'd20, 32'd3);
        wait_rdy(lat);
        check("b2b.first_latency", 32'(lat), 32'd33);
        check("b2b.first_result", data_result, 32'd6);
        check("b2b.first_remainder", data_remainder, 32'd2);
        drive_start(32'd21, 32'd4);
        check("b2b.rdy_dropped", 32'(data_resultRDY), 32'd0);
        check("b2b.busy", 32'(busy), 32'd1);
        wait_rdy(lat);
        check("b2b.second_latency", 32'(lat), 32'd33);
        check("b2b.second_result", data_result, 32'd5);
        check("b2b.second_remainder", data_remainder, 32'd1);
        @(posedge clock);
        #1;

        // asynchronous reset at E15
        @(negedge clock);
        drive_start(32'd100, 32'd7);
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midreset.result", data_result, 32'd0);
        check("midreset.remainder", data_remainder, 32'd0);
        check("midreset.exception", 32'(data_exception), 32'd0);
        check("midreset.rdy", 32'(data_resultRDY), 32'd0);
        check("midreset.busy", 32'(busy), 32'd0);
        check("midreset.state", 32'(fsm_state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        check("midreset.no_rdy", 32'(pulses), 32'd0);
        run_and_check("post_reset", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0);

        // random operands vs reference model
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = 32'($urandom_range(0, 100)) - 32'd50; b = 32'($urandom_range(0, 20)) - 32'd10; end
                2: begin a = $urandom; b = 32'($urandom_range(0, 16)) - 32'd8; end
                default: begin
                    a = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : $urandom;
                    b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd0;
                end
            endcase
            ref_div(a, b, q, r, e);
            exp_q.push_back(q);
            exp_r_q.push_back(r);
            exp_e_q.push_back(e);
            @(negedge clock);
            drive_start(a, b);
            wait_rdy(lat);
            check("rand.latency", 32'(lat), 32'd33);
            check("rand.result", data_result, exp_q.pop_front());
            check("rand.remainder", data_remainder, exp_r_q.pop_front());
            check("rand.exception", 32'(data_exception), 32'(exp_e_q.pop_front()));
            @(posedge clock);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
